// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - Gray-code states, direction and transition classes for the quadrature step decoder
package quad_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    TR_NONE    = 2'd0,
    TR_FWD     = 2'd1,
    TR_BWD     = 2'd2,
    TR_ILLEGAL = 2'd3
  } trans_e;

  // Clockwise successor in the Gray sequence 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      S00:     n = S01;
      S01:     n = S11;
      S11:     n = S10;
      default: n = S00;
    endcase
    return n;
  endfunction

  function automatic trans_e classify(input logic [1:0] prev, input logic [1:0] cur);
    trans_e t;
    if (cur == prev) begin
      t = TR_NONE;
    end else if ((cur ^ prev) == 2'b11) begin
      t = TR_ILLEGAL;
    end else if (cur == fwd_next(prev)) begin
      t = TR_FWD;
    end else begin
      t = TR_BWD;
    end
    return t;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - two-flop synchronizer plus stable-count debouncer for one encoder channel
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic rst_n_a,
  input  logic raw_i,
  output logic db_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          ff1_q;
  logic          ff2_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The edge that would bring the count to DEBOUNCE_CYCLES instead commits the new level.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (ff2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = ff2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      ff1_q <= IDLE_LEVEL;
      ff2_q <= IDLE_LEVEL;
      db_q  <= IDLE_LEVEL;
      cnt_q <= '0;
    end else begin
      ff1_q <= raw_i;
      ff2_q <= ff1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature encoder to counter enable/up_down front end with error flagging
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGES_PER_STEP  = 4,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic rst_n_a,
  input  logic enc_a,
  input  logic enc_b,
  input  logic clr_err,
  output logic step_en,
  output logic step_up,
  output logic err,
  output logic err_flag
);

  localparam logic signed [2:0] ACC_MAX = 3'(EDGES_PER_STEP - 1);
  localparam logic signed [2:0] ACC_MIN = 3'(1 - EDGES_PER_STEP);

  logic              a_db;
  logic              b_db;
  logic [1:0]        cur;
  logic [1:0]        prev_q;
  logic [1:0]        prev_d;
  logic signed [2:0] acc_q;
  logic signed [2:0] acc_d;
  logic              step_en_q;
  logic              step_en_d;
  logic              step_up_q;
  logic              step_up_d;
  logic              err_q;
  logic              err_d;
  logic              err_flag_q;
  logic              err_flag_d;
  trans_e            tr;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .IDLE_LEVEL     (IDLE_LEVEL)
  ) u_sync_a (
    .clk    (clk),
    .rst_n_a(rst_n_a),
    .raw_i  (enc_a),
    .db_o   (a_db)
  );

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .IDLE_LEVEL     (IDLE_LEVEL)
  ) u_sync_b (
    .clk    (clk),
    .rst_n_a(rst_n_a),
    .raw_i  (enc_b),
    .db_o   (b_db)
  );

  assign cur = {a_db, b_db};
  assign tr  = classify(prev_q, cur);

  always_comb begin
    prev_d     = cur;
    acc_d      = acc_q;
    step_en_d  = 1'b0;
    step_up_d  = step_up_q;
    err_d      = 1'b0;
    err_flag_d = err_flag_q;
    if (clr_err) begin
      err_flag_d = 1'b0;
    end
    case (tr)
      TR_FWD: begin
        if (acc_q == ACC_MAX) begin
          step_en_d = 1'b1;
          step_up_d = DIR_UP;
          acc_d     = '0;
        end else begin
          acc_d = acc_q + 3'sd1;
        end
      end
      TR_BWD: begin
        if (acc_q == ACC_MIN) begin
          step_en_d = 1'b1;
          step_up_d = DIR_DOWN;
          acc_d     = '0;
        end else begin
          acc_d = acc_q - 3'sd1;
        end
      end
      // A new illegal transition outranks a clear arriving on the same edge.
      TR_ILLEGAL: begin
        err_d      = 1'b1;
        err_flag_d = 1'b1;
        acc_d      = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      prev_q     <= {IDLE_LEVEL, IDLE_LEVEL};
      acc_q      <= '0;
      step_en_q  <= 1'b0;
      step_up_q  <= DIR_UP;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      acc_q      <= acc_d;
      step_en_q  <= step_en_d;
      step_up_q  <= step_up_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign step_en  = step_en_q;
  assign step_up  = step_up_q;
  assign err      = err_q;
  assign err_flag = err_flag_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - scoreboard bench for quad_step_decoder at 4 and 1 edges per step
module tb_quad_step_decoder;

  localparam int DEB  = 4;
  localparam int HOLD = 10;

  typedef struct {
    int   kind;
    logic up;
    int   at;
  } evt_t;

  logic clk = 1'b0;
  logic rst_n_a;
  logic enc_a;
  logic enc_b;
  logic clr_err;
  logic se0, su0, er0, ef0;
  logic se1, su1, er1, ef1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  evt_t q0[$];
  evt_t q1[$];
  evt_t e0;
  evt_t e1;
  logic skip_su = 1'b0;
  logic su0_prev = 1'b1;
  logic su1_prev = 1'b1;

  quad_step_decoder #(.DEBOUNCE_CYCLES(DEB), .EDGES_PER_STEP(4), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst_n_a(rst_n_a), .enc_a(enc_a), .enc_b(enc_b), .clr_err(clr_err),
    .step_en(se0), .step_up(su0), .err(er0), .err_flag(ef0)
  );

  quad_step_decoder #(.DEBOUNCE_CYCLES(DEB), .EDGES_PER_STEP(1), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst_n_a(rst_n_a), .enc_a(enc_a), .enc_b(enc_b), .clr_err(clr_err),
    .step_en(se1), .step_up(su1), .err(er1), .err_flag(ef1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // kind: 1 = step pulse, 2 = err pulse
  task automatic cmp_evt(input string name, input evt_t e, input logic se, input logic su, input logic er);
    int k;
    k = (se ? 1 : 0) + (er ? 2 : 0);
    n_checks++;
    if (k != e.kind || cyc != e.at || (e.kind == 1 && su != e.up)) begin
      n_fail++;
      $display("FAIL %s: actual kind %0d up %0d cycle %0d required kind %0d up %0d cycle %0d",
               name, k, su, cyc, e.kind, e.up, e.at);
    end
  endtask

  task automatic expect_evt(input int k0, input logic u0, input int k1, input logic u1);
    if (k0 != 0) q0.push_back('{k0, u0, cyc + DEB + 3});
    if (k1 != 0) q1.push_back('{k1, u1, cyc + DEB + 3});
  endtask

  task automatic drive(input logic a, input logic b, input int k0, input logic u0, input int k1, input logic u1);
    enc_a = a;
    enc_b = b;
    expect_evt(k0, u0, k1, u1);
    repeat (HOLD) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (se0 || er0) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut4_unexpected_pulse: actual step_en %0d err %0d at cycle %0d required no pulse", se0, er0, cyc);
      end else begin
        e0 = q0.pop_front();
        cmp_evt("dut4_event", e0, se0, su0, er0);
      end
    end
    if (se1 || er1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1_unexpected_pulse: actual step_en %0d err %0d at cycle %0d required no pulse", se1, er1, cyc);
      end else begin
        e1 = q1.pop_front();
        cmp_evt("dut1_event", e1, se1, su1, er1);
      end
    end
  end

  always @(negedge clk) begin
    if (!skip_su && su0 != su0_prev) check("dut4_step_up_changes_with_step_en", se0, 1);
    if (!skip_su && su1 != su1_prev) check("dut1_step_up_changes_with_step_en", se1, 1);
    su0_prev <= su0;
    su1_prev <= su1;
  end

  initial begin
    rst_n_a = 1'b0;
    enc_a   = 1'b1;
    enc_b   = 1'b1;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_step_en", se0, 0);
    check("reset_step_up", su0, 1);
    check("reset_err", er0, 0);
    check("reset_err_flag", ef0, 0);
    check("reset1_step_en", se1, 0);
    check("reset1_step_up", su1, 1);
    rst_n_a = 1'b1;
    repeat (3) @(negedge clk);

    // Clockwise detent 11->10->00->01->11
    drive(1'b1, 1'b0, 0, 1'b0, 1, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b0, 1, 1'b1);
    drive(1'b0, 1'b1, 0, 1'b0, 1, 1'b1);
    drive(1'b1, 1'b1, 1, 1'b1, 1, 1'b1);

    // Counter-clockwise detent 11->01->00->10->11
    drive(1'b0, 1'b1, 0, 1'b0, 1, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0, 1, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0, 1, 1'b0);
    drive(1'b1, 1'b1, 1, 1'b0, 1, 1'b0);
    check("ccw_step_up_held_low", su0, 0);

    // Glitch shorter than the debounce window
    enc_a = 1'b0;
    repeat (3) @(negedge clk);
    enc_a = 1'b1;
    repeat (HOLD) @(negedge clk);

    // Reversal 11->10->00->10->11 nets to zero on the 4-edge decoder
    drive(1'b1, 1'b0, 0, 1'b0, 1, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b0, 1, 1'b1);
    drive(1'b1, 1'b0, 0, 1'b0, 1, 1'b0);
    drive(1'b1, 1'b1, 0, 1'b0, 1, 1'b0);
    repeat (60) @(negedge clk);
    check("reversal_step_up_still_low", su0, 0);

    // Illegal jump 11->00, then clear
    drive(1'b0, 1'b0, 2, 1'b0, 2, 1'b0);
    check("illegal_err_flag_set", ef0, 1);
    check("illegal1_err_flag_set", ef1, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_err_clears_flag", ef0, 0);
    check("clr_err1_clears_flag", ef1, 0);

    // Illegal jump 00->11 with clr_err on the same edge as the set
    enc_a = 1'b1;
    enc_b = 1'b1;
    expect_evt(2, 1'b0, 2, 1'b0);
    repeat (DEB + 2) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    repeat (HOLD - DEB - 3) @(negedge clk);
    check("set_wins_over_clr", ef0, 1);
    check("set_wins_over_clr1", ef1, 1);

    // Two forward edges, then reset mid-operation
    drive(1'b1, 1'b0, 0, 1'b0, 1, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b0, 1, 1'b1);
    skip_su = 1'b1;
    rst_n_a = 1'b0;
    #1;
    check("midreset_step_en", se0, 0);
    check("midreset_step_up", su0, 1);
    check("midreset_err_flag", ef0, 0);
    check("midreset1_err_flag", ef1, 0);
    enc_a = 1'b1;
    enc_b = 1'b1;
    @(negedge clk);
    rst_n_a = 1'b1;
    repeat (3) @(negedge clk);
    skip_su = 1'b0;
    drive(1'b1, 1'b0, 0, 1'b0, 1, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b0, 1, 1'b1);

    repeat (20) @(negedge clk);
    check("dut4_all_expected_pulses_seen", q0.size(), 0);
    check("dut1_all_expected_pulses_seen", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Front end for the up/down counter's control interface: turns a two-channel mechanical quadrature encoder (enc_a, enc_b) into the one-cycle enable pulse and up/down direction that the counter consumes.
- Synchronizes and debounces both channels, decodes Gray-code transitions, and accumulates edges into detent-sized steps.
- Flags illegal transitions.
- Sits between the board encoder pins and the counter's enable/up_down inputs.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive clocks a synchronized channel must differ from its debounced value before the change is accepted; legal range 1..255.
- EDGES_PER_STEP, 4: Gray transitions per emitted step; legal values 1, 2, 4.
- IDLE_LEVEL, 1: reset level of synchronizer and debounced registers on both channels (pull-up detent = 11).

Ports:
- clk  input  1  system clock
- rst_n_a  input  1  reset, asynchronous, active-low
- enc_a  input  1  raw encoder channel A, asynchronous to clk
- enc_b  input  1  raw encoder channel B, asynchronous to clk
- clr_err  input  1  synchronous clear of err_flag
- step_en  output  1  one-clock pulse per accepted step; drives counter enable
- step_up  output  1  direction of last step (1 = up/CW); drives counter up_down; held between pulses
- err  output  1  one-clock pulse on illegal transition
- err_flag  output  1  sticky illegal-transition flag

Behaviour:
- Reset (async assert, sync-free release):
  - Sync FFs and debounced a/b = IDLE_LEVEL; prev state = {IDLE_LEVEL, IDLE_LEVEL}.
  - Debounce counters = 0; acc = 0.
  - step_en = 0, step_up = 1, err = 0, err_flag = 0.
  - Reset mid-operation discards any partial accumulation.
- Synchronizer: two FFs per channel; the second FF output is the synced value.
- Debounce, per channel independently:
  - If synced != debounced, the counter increments. When the count reaches DEBOUNCE_CYCLES, debounced takes the synced value at that edge and the counter clears.
  - Any cycle with synced == debounced clears the counter.
  - Counter width = clog2(DEBOUNCE_CYCLES+1).
- Decode: compare cur = {a_db, b_db} with prev each cycle; prev <= cur.
  - Forward (+1): 00->01, 01->11, 11->10, 10->00.
  - Backward (-1): the reverse of each forward transition.
  - No change: no action.
  - Illegal (both bits differ):
    - err = 1 for one cycle, err_flag set, acc cleared, no step.
    - Includes both channels' debounce completing on the same edge.
- Accumulator: signed 3-bit acc, range -(EDGES_PER_STEP-1)..+(EDGES_PER_STEP-1).
  - Forward transition:
    - If acc == EDGES_PER_STEP-1: step_en = 1, step_up = 1, acc = 0.
    - Otherwise acc + 1.
  - Backward transition:
    - If acc == -(EDGES_PER_STEP-1): step_en = 1, step_up = 0, acc = 0.
    - Otherwise acc - 1.
  - Direction reversals cancel naturally; no step is emitted on net-zero motion.
  - EDGES_PER_STEP = 1: every legal transition emits a step.
- Output timing:
  - step_en and err are registered and high for exactly one clock.
  - Let edge k be the first edge at which FF1 samples a new level that is then held stable. Debounced update occurs at edge k+DEBOUNCE_CYCLES+1; step_en/err are high after edge k+DEBOUNCE_CYCLES+2.
- Pulse spacing and direction:
  - Two steps never merge, because every transition needs a debounced update at least one cycle apart.
  - step_up changes only together with a step_en pulse.
- err_flag:
  - Set by an illegal transition; cleared by clr_err.
  - Simultaneous set and clr_err: set wins.

Decomposition:
- Package quad_pkg:
  - 2-bit Gray state constants S00, S01, S11, S10.
  - Direction encoding DIR_UP = 1, DIR_DOWN = 0.
  - Transition-class encoding NONE / FWD / BWD / ILLEGAL.
  - Function classifying a prev/cur pair into a transition class.
- Sub-module sync_debounce (2-FF synchronizer + debounce counter; params DEBOUNCE_CYCLES, IDLE_LEVEL), instantiated once per channel.
- Top-level module holds the decode, accumulator and output registers.

Test Plan (DEBOUNCE_CYCLES = 4, EDGES_PER_STEP = 4 unless noted; each level held 10 clocks):
- CW detent 11->10->00->01->11 -> exactly one step_en, with step_up = 1, 6 clocks after FF1 first samples the final 11; no err.
- CCW detent 11->01->00->10->11 -> one step_en with step_up = 0; step_up stays 0 afterwards; counter under test decrements once.
- Glitch: enc_a low for 3 clocks, then high (< DEBOUNCE_CYCLES) -> debounced a stays 1; no step_en, no err.
- Reversal 11->10->00->10->11 -> acc returns to 0; no step_en over 100 clocks.
- Illegal jump 11->00 (both channels toggled on the same clock) -> err pulse one clock, err_flag = 1, no step_en. A following clr_err pulse clears err_flag; clr_err coincident with a second illegal jump leaves err_flag = 1.
- Reset mid-operation: two forward transitions, then rst_n_a low for 1 clock.
  - Outputs immediately read step_en = 0, step_up = 1, err_flag = 0.
  - Two further forward transitions produce no step.
  - With EDGES_PER_STEP = 1, the same sequence yields one step_en per transition.
